// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot pixel writer and the engine side.
// Holds the writer state encoding and the iteration-to-colour mapping, so
// the engine and the writer always agree on how a result becomes a pixel.
package mandelbrot_pkg;

    // Writer control states: waiting for a region, accepting results,
    // flushing the last results out to video RAM.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } writerState_e;

    // Native colour width produced by the mapping (4:4:4).
    localparam int ColourW = 12;

    // Points that never diverged are inside the set and are painted black.
    // Otherwise the low three iteration nibbles are reversed, so the fast
    // changing low nibble lands in the red channel.
    function automatic logic [ColourW-1:0] iterToColour(input logic [11:0] iter,
                                                        input logic       diverged);
        if (!diverged) begin
            return '0;
        end
        return {iter[3:0], iter[7:4], iter[11:8]};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO with occupancy count.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   push_i, wdata_i    write strobe and data (ignored when full unless popping)
//   pop_i, rdata_o     read strobe and head-of-queue data (show-ahead)
//   count_o            number of stored entries, 0..DEPTH
//   full_o, empty_o    occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wrPtr_q;
    logic [PtrW-1:0]  rdPtr_q;
    logic [PtrW:0]    count_q;
    logic             doPush;
    logic             doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW+1)'(DEPTH));
    assign doPop   = pop_i && !empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign doPush  = push_i && (!full_o || doPop);
    assign rdata_o = mem_q[rdPtr_q];
    assign count_o = count_q;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers simply wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mandelbrot_pixel_writer.sv
// Turns Mandelbrot engine results into video RAM write requests.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   start, x/y_origin, real/imag_size   region setup, sampled on start in IDLE
//   in_valid, in_real_cnt, in_imag_cnt, in_iteration, in_diverged   results
//   stall                           registered back-pressure to the engine
//   vram_req, vram_addr, vram_data, vram_ready   write handshake
//   busy, done, overflow            status (done one cycle, overflow sticky)
module mandelbrot_pixel_writer
    import mandelbrot_pkg::*;
#(
    parameter int ITERW = 16,
    parameter int RCNTW = 10,
    parameter int ICNTW = 10,
    parameter int ADDRW = 19,
    parameter int RGBW  = 12,
    parameter int HSIZE = 640,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RCNTW-1:0] x_origin,
    input  logic [ICNTW-1:0] y_origin,
    input  logic [RCNTW-1:0] real_size,
    input  logic [ICNTW-1:0] imag_size,
    input  logic             in_valid,
    input  logic [RCNTW-1:0] in_real_cnt,
    input  logic [ICNTW-1:0] in_imag_cnt,
    input  logic [ITERW-1:0] in_iteration,
    input  logic             in_diverged,
    output logic             stall,
    output logic             vram_req,
    output logic [ADDRW-1:0] vram_addr,
    output logic [RGBW-1:0]  vram_data,
    input  logic             vram_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int CntW = $clog2(DEPTH) + 1;

    writerState_e     state_q, state_d;
    logic [RCNTW-1:0] xOrigin_q, realSize_q;
    logic [ICNTW-1:0] yOrigin_q, imagSize_q;
    logic             s1Valid_q, s1Valid_d;
    logic [ADDRW-1:0] s1Addr_q, s1Addr_d;
    logic [RGBW-1:0]  s1Colour_q, s1Colour_d;
    logic             stall_q, stall_d;
    logic             overflow_q, overflow_d;

    logic [ADDRW+RGBW-1:0] fifoRdata;
    logic [CntW-1:0]       fifoCount;
    logic                  fifoFull, fifoEmpty;
    logic                  vramPop, pushAccepted, isLast;
    logic [CntW:0]         occNext;

    logic [ITERW+11:0]     iterExt;
    logic [ColourW-1:0]    colour12;
    logic [31:0]           xPix, yPix, addrWide;
    logic                  unusedBits;

    assign isLast       = (in_real_cnt == realSize_q) && (in_imag_cnt == imagSize_q);
    assign vramPop      = vram_req && vram_ready;
    assign pushAccepted = s1Valid_q && (!fifoFull || vramPop);

    // Stage 1 combinational part: framebuffer address and colour of the
    // incoming result. Only results arriving while ACTIVE enter the pipe.
    always_comb begin
        iterExt    = {{12{1'b0}}, in_iteration};
        colour12   = iterToColour(iterExt[11:0], in_diverged);
        xPix       = 32'(xOrigin_q) + 32'(in_real_cnt);
        yPix       = 32'(yOrigin_q) + 32'(in_imag_cnt);
        addrWide   = yPix * 32'(HSIZE) + xPix;
        s1Addr_d   = addrWide[ADDRW-1:0];
        s1Valid_d  = in_valid && (state_q == ACTIVE);
    end

    // High iteration bits and the address bits above ADDRW are deliberately discarded.
    assign unusedBits = ^{iterExt[ITERW+11:12], addrWide[31:ADDRW]};

    // Fit the 12-bit 4:4:4 colour into the RAM word width: MSB-aligned.
    generate
        if (RGBW == ColourW) begin : gColourExact
            assign s1Colour_d = colour12;
        end else if (RGBW > ColourW) begin : gColourWide
            assign s1Colour_d = {colour12, {(RGBW-ColourW){1'b0}}};
        end else begin : gColourNarrow
            logic unusedColourLsbs;
            assign s1Colour_d       = colour12[ColourW-1 -: RGBW];
            assign unusedColourLsbs = ^colour12[ColourW-RGBW-1:0];
        end
    endgenerate

    // Occupancy one cycle ahead, so the registered stall reflects the
    // pipe plus FIFO contents of the cycle in which it is seen.
    always_comb begin
        occNext = {1'b0, fifoCount} + (CntW+1)'(pushAccepted)
                + (CntW+1)'(s1Valid_d) - (CntW+1)'(vramPop);
        stall_d = (occNext >= (CntW+1)'(DEPTH-2));
    end

    // Overflow clears on an accepted start and latches when a result is
    // dropped because the FIFO is full and nothing leaves this cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (state_q == IDLE && start) begin
            overflow_d = 1'b0;
        end else if (s1Valid_q && !pushAccepted) begin
            overflow_d = 1'b1;
        end
    end

    // Control FSM next state. DRAIN finishes once neither the pipe stage
    // nor the FIFO holds anything; done is raised in that same cycle.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE:    if (start) state_d = ACTIVE;
            ACTIVE:  if (in_valid && isLast) state_d = DRAIN;
            DRAIN: begin
                if (!s1Valid_q && fifoEmpty) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, region setup, pipe stage and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            xOrigin_q  <= '0;
            yOrigin_q  <= '0;
            realSize_q <= '0;
            imagSize_q <= '0;
            s1Valid_q  <= 1'b0;
            s1Addr_q   <= '0;
            s1Colour_q <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1Valid_q  <= s1Valid_d;
            s1Addr_q   <= s1Addr_d;
            s1Colour_q <= s1Colour_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
            if (state_q == IDLE && start) begin
                xOrigin_q  <= x_origin;
                yOrigin_q  <= y_origin;
                realSize_q <= real_size;
                imagSize_q <= imag_size;
            end
        end
    end

    sync_fifo #(
        .WIDTH(ADDRW + RGBW),
        .DEPTH(DEPTH)
    ) uFifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (s1Valid_q),
        .pop_i   (vramPop),
        .wdata_i ({s1Addr_q, s1Colour_q}),
        .rdata_o (fifoRdata),
        .count_o (fifoCount),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // The head entry is shown only while a request is up, so the bus reads
    // zero when idle instead of stale FIFO contents.
    assign vram_req  = !fifoEmpty;
    assign vram_addr = vram_req ? fifoRdata[ADDRW+RGBW-1:RGBW] : '0;
    assign vram_data = vram_req ? fifoRdata[RGBW-1:0] : '0;
    assign stall     = stall_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mandelbrot_pixel_writer.sv
// Self-checking bench for mandelbrot_pixel_writer: constant vector table,
// hand-written corner sequences and randomized regions against a pixel model.
module tb_mandelbrot_pixel_writer;

    localparam int ITERW = 16;
    localparam int RCNTW = 10;
    localparam int ICNTW = 10;
    localparam int ADDRW = 19;
    localparam int RGBW  = 12;
    localparam int HSIZE = 640;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst, start, in_valid, in_diverged, vram_ready;
    logic [RCNTW-1:0] x_origin, real_size, in_real_cnt;
    logic [ICNTW-1:0] y_origin, imag_size, in_imag_cnt;
    logic [ITERW-1:0] in_iteration;
    logic             stall, vram_req, busy, done, overflow;
    logic [ADDRW-1:0] vram_addr;
    logic [RGBW-1:0]  vram_data;

    always #5 clk = ~clk;

    mandelbrot_pixel_writer #(
        .ITERW(ITERW), .RCNTW(RCNTW), .ICNTW(ICNTW), .ADDRW(ADDRW),
        .RGBW(RGBW), .HSIZE(HSIZE), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .x_origin(x_origin), .y_origin(y_origin),
        .real_size(real_size), .imag_size(imag_size),
        .in_valid(in_valid), .in_real_cnt(in_real_cnt), .in_imag_cnt(in_imag_cnt),
        .in_iteration(in_iteration), .in_diverged(in_diverged),
        .stall(stall), .vram_req(vram_req), .vram_addr(vram_addr),
        .vram_data(vram_data), .vram_ready(vram_ready),
        .busy(busy), .done(done), .overflow(overflow)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } pixel_t;

    typedef struct {
        logic [9:0]  xo, yo, rx, iy;
        logic [15:0] it;
        logic        dv;
        logic [31:0] expAddr, expData;
    } vec_t;

    pixel_t      expQ[$];
    pixel_t      obsQ[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          doneSeen = 0;
    int          lastAcceptCyc = -1;
    int          doneCyc = -1;
    int          readyMode = 0;
    int unsigned regXo, regYo;

    // Cycle counter and VRAM ready driver (0 low, 1 high, 2 random), applied
    // after the main thread has had its chance to change the mode.
    always @(posedge clk) begin
        cyc++;
        #2;
        case (readyMode)
            0:       vram_ready = 1'b0;
            1:       vram_ready = 1'b1;
            default: vram_ready = 1'($urandom % 2);
        endcase
    end

    // Write and done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (vram_req && vram_ready) begin
            pixel_t p;
            p.addr = 32'(vram_addr);
            p.data = 32'(vram_data);
            obsQ.push_back(p);
            lastAcceptCyc = cyc;
        end
        if (done) begin
            doneSeen++;
            doneCyc = cyc;
        end
    end

    // Reference pixel: raster address modulo the RAM size, nibble-reversed colour.
    function automatic pixel_t modelPixel(input int unsigned xo, input int unsigned yo,
                                          input int unsigned ix, input int unsigned iy,
                                          input int unsigned it, input bit dv);
        pixel_t p;
        int unsigned hs;
        hs     = HSIZE;
        p.addr = ((yo + iy) * hs + (xo + ix)) % (32'd1 << ADDRW);
        p.data = dv ? (((it & 32'hF) << 8) | (((it >> 4) & 32'hF) << 4) | ((it >> 8) & 32'hF)) : 32'd0;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    // One engine result for one cycle; its expected write joins the model queue.
    task automatic applyStimulus(input int unsigned ix, input int unsigned iy,
                                 input int unsigned it, input bit dv);
        in_valid     = 1'b1;
        in_real_cnt  = RCNTW'(ix);
        in_imag_cnt  = ICNTW'(iy);
        in_iteration = ITERW'(it);
        in_diverged  = dv;
        expQ.push_back(modelPixel(regXo, regYo, ix, iy, it, dv));
        step();
        in_valid = 1'b0;
    endtask

    task automatic armRegion(input int unsigned xo, input int unsigned yo,
                             input int unsigned rs, input int unsigned is);
        x_origin  = RCNTW'(xo);
        y_origin  = ICNTW'(yo);
        real_size = RCNTW'(rs);
        imag_size = ICNTW'(is);
        regXo     = xo;
        regYo     = yo;
        start     = 1'b1;
        step();
        start = 1'b0;
        expQ.delete();
        obsQ.delete();
        doneSeen      = 0;
        lastAcceptCyc = -1;
        doneCyc       = -1;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        while (doneSeen == 0 && n < budget) begin
            step();
            n++;
        end
        step();
        step();
        checkOutput({name, " done count"}, 32'(doneSeen), 32'd1);
    endtask

    task automatic compareWrites(input string name);
        checkOutput({name, " write count"}, 32'(obsQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            checkOutput($sformatf("%s pix%0d addr", name, i), obsQ[i].addr, expQ[i].addr);
            checkOutput($sformatf("%s pix%0d data", name, i), obsQ[i].data, expQ[i].data);
        end
    endtask

    task automatic waitNoStall(input string name, output bit ok);
        int n = 0;
        while (stall && n < 300) begin
            step();
            n++;
        end
        ok = !stall;
        if (!ok) checkOutput({name, " stall timeout"}, 32'(stall), 32'd0);
    endtask

    // Full raster region with an engine that honours stall, random gaps and
    // stray start pulses that must be ignored while busy.
    task automatic runRegion(input string name, input int unsigned xo, input int unsigned yo,
                             input int unsigned rs, input int unsigned is, input int mode);
        bit ok;
        armRegion(xo, yo, rs, is);
        readyMode = mode;
        for (int unsigned y = 0; y <= is; y++) begin
            for (int unsigned x = 0; x <= rs; x++) begin
                if ($urandom % 4 == 0) begin
                    if ($urandom % 2 == 0) begin
                        x_origin  = RCNTW'($urandom);
                        y_origin  = ICNTW'($urandom);
                        real_size = RCNTW'($urandom);
                        start     = 1'b1;
                    end
                    step();
                    start = 1'b0;
                end
                waitNoStall(name, ok);
                if (!ok) return;
                applyStimulus(x, y, $urandom & 32'hFFFF, 1'($urandom % 2));
            end
        end
        waitDone(name, 2000);
        readyMode = 0;
        compareWrites(name);
        checkOutput({name, " done after last write"}, 32'(doneCyc), 32'(lastAcceptCyc + 1));
        checkOutput({name, " overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        vec_t vecs[5];
        int unsigned req37[4];
        int sent;
        bit ok;

        vecs[0] = '{10'd0,    10'd0,    10'd0,    10'd0,    16'h0FFF, 1'b0, 32'd0,      32'h000};
        vecs[1] = '{10'd0,    10'd0,    10'd1,    10'd1,    16'h0123, 1'b1, 32'd641,    32'h321};
        vecs[2] = '{10'd10,   10'd2,    10'd5,    10'd3,    16'h0ABC, 1'b1, 32'd3215,   32'hCBA};
        vecs[3] = '{10'd1023, 10'd1023, 10'd1023, 10'd1023, 16'hFFFF, 1'b1, 32'd262910, 32'hFFF};
        vecs[4] = '{10'd3,    10'd0,    10'd2,    10'd0,    16'h0010, 1'b1, 32'd5,      32'h010};
        req37 = '{0, 1, 640, 641};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_diverged = 1'b0; vram_ready = 1'b0;
        x_origin = '0; y_origin = '0; real_size = '0; imag_size = '0;
        in_real_cnt = '0; in_imag_cnt = '0; in_iteration = '0;
        step();
        step();
        checkOutput("reset vram_req", 32'(vram_req), 32'd0);
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        checkOutput("reset addr", 32'(vram_addr), 32'd0);
        checkOutput("reset data", 32'(vram_data), 32'd0);
        rst = 1'b0;
        step();

        // Results while IDLE produce nothing.
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        checkOutput("idle ignores in_valid", 32'(vram_req), 32'd0);

        // Single-pixel regions from the table: latency, address, colour, done.
        for (int i = 0; i < 5; i++) begin
            armRegion(vecs[i].xo, vecs[i].yo, vecs[i].rx, vecs[i].iy);
            readyMode = 0;
            applyStimulus(vecs[i].rx, vecs[i].iy, vecs[i].it, vecs[i].dv);
            checkOutput($sformatf("vec%0d req at +1", i), 32'(vram_req), 32'd0);
            step();
            checkOutput($sformatf("vec%0d req at +2", i), 32'(vram_req), 32'd1);
            checkOutput($sformatf("vec%0d addr", i), 32'(vram_addr), vecs[i].expAddr);
            checkOutput($sformatf("vec%0d data", i), 32'(vram_data), vecs[i].expData);
            readyMode = 1;
            step();
            readyMode = 0;
            checkOutput($sformatf("vec%0d done", i), 32'(done), 32'd1);
            step();
            checkOutput($sformatf("vec%0d idle", i), 32'(busy), 32'd0);
        end

        // 2x2 region at the origin with the RAM always ready.
        runRegion("square", 0, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < obsQ.size()) checkOutput($sformatf("square order%0d", i), obsQ[i].addr, req37[i]);
            else checkOutput($sformatf("square order%0d missing", i), 32'(obsQ.size()), 32'(i + 1));
        end

        // RAM held off: an engine honouring stall gets exactly 6 results in.
        armRegion(0, 5, 7, 0);
        readyMode = 0;
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            if (!stall && sent < 8) begin
                applyStimulus(sent, 0, $urandom & 32'hFFFF, 1'b1);
                sent++;
            end else begin
                step();
            end
        end
        checkOutput("stall cap results", 32'(sent), 32'd6);
        checkOutput("stall held", 32'(stall), 32'd1);
        checkOutput("stall no overflow", 32'(overflow), 32'd0);
        readyMode = 1;
        while (sent < 8) begin
            waitNoStall("stall resume", ok);
            if (!ok) break;
            applyStimulus(sent, 0, $urandom & 32'hFFFF, 1'b1);
            sent++;
        end
        waitDone("stall", 500);
        readyMode = 0;
        compareWrites("stall");
        checkOutput("stall end overflow", 32'(overflow), 32'd0);

        // Stall ignored with RAM held off: the 9th result is dropped.
        armRegion(0, 0, 15, 0);
        readyMode = 0;
        for (int unsigned k = 0; k < 9; k++) applyStimulus(k, 0, k * 32'h111, 1'b1);
        expQ.delete(8);
        checkOutput("overflow before drop", 32'(overflow), 32'd0);
        step();
        checkOutput("overflow set", 32'(overflow), 32'd1);
        step(); step(); step();
        checkOutput("overflow sticky", 32'(overflow), 32'd1);
        readyMode = 1;
        waitNoStall("overflow drain", ok);
        if (ok) applyStimulus(15, 0, 32'h0456, 1'b1);
        waitDone("overflow", 500);
        readyMode = 0;
        compareWrites("overflow");
        checkOutput("overflow after done", 32'(overflow), 32'd1);

        // Push and pop on a full FIFO in the same cycle must not drop.
        armRegion(100, 7, 8, 0);
        checkOutput("start clears overflow", 32'(overflow), 32'd0);
        readyMode = 0;
        for (int unsigned k = 0; k < 9; k++) applyStimulus(k, 0, 32'h0F00 + k, 1'b1);
        readyMode = 1;
        step();
        checkOutput("full push+pop overflow", 32'(overflow), 32'd0);
        waitDone("fullpp", 500);
        readyMode = 0;
        compareWrites("fullpp");

        // Random regions with a RAM that accepts on random cycles.
        for (int r = 0; r < 3; r++) begin
            runRegion($sformatf("rand%0d", r), $urandom % 1024, $urandom % 1024,
                      $urandom % 5, $urandom % 5, 2);
        end

        // Reset in the middle of a region with three writes pending.
        armRegion(0, 0, 3, 3);
        readyMode = 0;
        applyStimulus(0, 0, 32'h1, 1'b1);
        applyStimulus(1, 0, 32'h2, 1'b1);
        applyStimulus(2, 0, 32'h3, 1'b1);
        step(); step();
        checkOutput("pending before reset", 32'(vram_req), 32'd1);
        rst = 1'b1;
        step();
        checkOutput("reset mid vram_req", 32'(vram_req), 32'd0);
        checkOutput("reset mid busy", 32'(busy), 32'd0);
        checkOutput("reset mid addr", 32'(vram_addr), 32'd0);
        checkOutput("reset mid stall", 32'(stall), 32'd0);
        rst = 1'b0;
        step(); step(); step(); step();
        checkOutput("reset mid no done", 32'(doneSeen), 32'd0);
        checkOutput("reset mid no writes", 32'(vram_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
